// File: rtl/addr_gen_pkg.sv
// Shared types and default widths for the sliding-window address generator.
package addr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_DIM_WIDTH    = 6;
    localparam int DEF_STRIDE_WIDTH = 2;
    localparam int DEF_KERNEL_SIZE  = 3;

endpackage

// File: rtl/window_tap_addr.sv
// Combinational tap-address generator for one KERNEL_SIZE x KERNEL_SIZE window,
// row-major, truncated to ADDR_WIDTH only after the full-width sum.
module window_tap_addr
    import addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH   = DEF_DIM_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
    input  logic [ADDR_WIDTH-1:0]                                  start_addr,
    input  logic [DIM_WIDTH-1:0]                                   size,
    input  logic [DIM_WIDTH-1:0]                                   row,
    input  logic [DIM_WIDTH-1:0]                                   col,
    output logic [0:KERNEL_SIZE*KERNEL_SIZE-1][ADDR_WIDTH-1:0]     addr
);

    localparam int PW = ADDR_WIDTH + 2*DIM_WIDTH + 4;

    for (genvar gx = 0; gx < KERNEL_SIZE; gx++) begin : g_row
        for (genvar gy = 0; gy < KERNEL_SIZE; gy++) begin : g_col
            logic [PW-1:0] lin;
            assign lin = PW'(start_addr)
                       + (PW'(row) + PW'(gx)) * PW'(size)
                       + PW'(col) + PW'(gy);
            assign addr[gx*KERNEL_SIZE + gy] = lin[ADDR_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/window_address_sequencer.sv
// Walks every window of a square feature map at a programmable stride and
// presents each window's tap addresses with valid/ready flow control.
//   state | meaning
//   IDLE  | waiting for i_start; invalid configs pulse o_error here
//   RUN   | presenting windows, advancing on each handshake
//   DONE  | one-cycle o_done after the final window was accepted
module window_address_sequencer
    import addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH    = DEF_DIM_WIDTH,
    parameter int STRIDE_WIDTH = DEF_STRIDE_WIDTH,
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE
) (
    input  logic                                                i_clk,
    input  logic                                                i_nrst,
    input  logic                                                i_reg_clear,
    input  logic                                                i_start,
    input  logic [DIM_WIDTH-1:0]                                i_i_size,
    input  logic [STRIDE_WIDTH-1:0]                             i_stride,
    input  logic [ADDR_WIDTH-1:0]                               i_start_addr,
    input  logic                                                i_ready,
    output logic                                                o_valid,
    output logic [0:KERNEL_SIZE*KERNEL_SIZE-1][ADDR_WIDTH-1:0]  o_addr,
    output logic [DIM_WIDTH-1:0]                                o_o_x,
    output logic [DIM_WIDTH-1:0]                                o_o_y,
    output logic                                                o_last,
    output logic                                                o_busy,
    output logic                                                o_done,
    output logic                                                o_error
);

    localparam int DATA_LENGTH = KERNEL_SIZE*KERNEL_SIZE;
    localparam int CW          = DIM_WIDTH + STRIDE_WIDTH + 8;

    state_t                   state_q, state_d;
    logic [DIM_WIDTH-1:0]     size_q, size_d;
    logic [STRIDE_WIDTH-1:0]  stride_q, stride_d;
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [DIM_WIDTH-1:0]     row_q, row_d, col_q, col_d;
    logic [DIM_WIDTH-1:0]     ox_d, oy_d;
    logic                     valid_d, done_d, error_d, last_d;
    logic                     col_adv, row_adv, cfg_bad;
    logic [0:DATA_LENGTH-1][ADDR_WIDTH-1:0] taps;

    assign col_adv = (CW'(col_q) + CW'(stride_q) + CW'(KERNEL_SIZE)) <= CW'(size_q);
    assign row_adv = (CW'(row_q) + CW'(stride_q) + CW'(KERNEL_SIZE)) <= CW'(size_q);
    assign cfg_bad = (i_stride == '0) || (CW'(i_i_size) < CW'(KERNEL_SIZE));

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        stride_d = stride_q;
        base_d   = base_q;
        row_d    = row_q;
        col_d    = col_q;
        ox_d     = o_o_x;
        oy_d     = o_o_y;
        valid_d  = o_valid;
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (i_start) begin
                    size_d   = i_i_size;
                    stride_d = i_stride;
                    base_d   = i_start_addr;
                    if (cfg_bad) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        row_d   = '0;
                        col_d   = '0;
                        ox_d    = '0;
                        oy_d    = '0;
                        valid_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (o_valid && i_ready) begin
                    if (col_adv) begin
                        col_d = col_q + DIM_WIDTH'(stride_q);
                        oy_d  = o_o_y + 1'b1;
                    end else if (row_adv) begin
                        col_d = '0;
                        oy_d  = '0;
                        row_d = row_q + DIM_WIDTH'(stride_q);
                        ox_d  = o_o_x + 1'b1;
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        // Last-window flag is computed for the window about to be presented.
        last_d = !((CW'(col_d) + CW'(stride_d) + CW'(KERNEL_SIZE)) <= CW'(size_d)) &&
                 !((CW'(row_d) + CW'(stride_d) + CW'(KERNEL_SIZE)) <= CW'(size_d));
    end

    window_tap_addr #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DIM_WIDTH   (DIM_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_taps (
        .start_addr (base_d),
        .size       (size_d),
        .row        (row_d),
        .col        (col_d),
        .addr       (taps)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= IDLE;
            size_q   <= '0;
            stride_q <= '0;
            base_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            o_o_x    <= '0;
            o_o_y    <= '0;
            o_valid  <= 1'b0;
            o_addr   <= '0;
            o_last   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_error  <= 1'b0;
        end else if (i_reg_clear) begin
            state_q  <= IDLE;
            size_q   <= '0;
            stride_q <= '0;
            base_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            o_o_x    <= '0;
            o_o_y    <= '0;
            o_valid  <= 1'b0;
            o_addr   <= '0;
            o_last   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_error  <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            stride_q <= stride_d;
            base_q   <= base_d;
            row_q    <= row_d;
            col_q    <= col_d;
            o_o_x    <= ox_d;
            o_o_y    <= oy_d;
            o_valid  <= valid_d;
            if (valid_d) begin
                o_addr <= taps;
            end
            o_last   <= valid_d && last_d;
            o_busy   <= (state_d != IDLE);
            o_done   <= done_d;
            o_error  <= error_d;
        end
    end

endmodule

// File: tb/tb_window_address_sequencer.sv
// Scoreboard bench for window_address_sequencer: stimulus queues expected
// windows, a monitor pops and compares on every handshake.
module tb_window_address_sequencer;

    localparam int AW = 8;
    localparam int DW = 6;
    localparam int SW = 2;
    localparam int K  = 3;
    localparam int DL = K*K;

    typedef logic [0:DL-1][AW-1:0] taps_t;
    typedef struct {
        taps_t         addr;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          last;
    } win_t;

    logic          i_clk, i_nrst, i_reg_clear, i_start, i_ready;
    logic [DW-1:0] i_i_size;
    logic [SW-1:0] i_stride;
    logic [AW-1:0] i_start_addr;
    logic          o_valid, o_last, o_busy, o_done, o_error;
    taps_t         o_addr;
    logic [DW-1:0] o_o_x, o_o_y;

    int   n_chk = 0;
    int   n_pass = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    win_t sb[$];

    window_address_sequencer #(
        .ADDR_WIDTH(AW), .DIM_WIDTH(DW), .STRIDE_WIDTH(SW), .KERNEL_SIZE(K)
    ) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear),
        .i_start(i_start), .i_i_size(i_i_size), .i_stride(i_stride),
        .i_start_addr(i_start_addr), .i_ready(i_ready),
        .o_valid(o_valid), .o_addr(o_addr), .o_o_x(o_o_x), .o_o_y(o_o_y),
        .o_last(o_last), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DL*AW-1:0] act,
                         input logic [DL*AW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compares every accepted window and verifies hold under backpressure.
    initial begin : monitor
        taps_t         h_addr;
        logic [DW-1:0] h_x, h_y;
        logic          h_last, h_stall;
        win_t          e;
        h_stall = 1'b0;
        h_addr  = '0;
        h_x     = '0;
        h_y     = '0;
        h_last  = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_nrst && o_valid) begin
                if (h_stall) begin
                    check("hold_addr", 72'(o_addr), 72'(h_addr));
                    check("hold_xy", 72'({o_o_x, o_o_y}), 72'({h_x, h_y}));
                    check("hold_last", 72'(o_last), 72'(h_last));
                end
                if (i_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_window", 72'(1), 72'(0));
                    end else begin
                        e = sb.pop_front();
                        acc_cnt++;
                        check("win_addr", 72'(o_addr), 72'(e.addr));
                        check("win_xy", 72'({o_o_x, o_o_y}), 72'({e.x, e.y}));
                        check("win_last", 72'(o_last), 72'(e.last));
                    end
                end
            end
            if (o_done) done_cnt++;
            h_stall = o_valid && !i_ready;
            h_addr  = o_addr;
            h_x     = o_o_x;
            h_y     = o_o_y;
            h_last  = o_last;
        end
    end

    task automatic load_model(input int size, input int stride, input int base);
        win_t w;
        int   ox, oy;
        ox = 0;
        for (int r = 0; r + K <= size; r += stride) begin
            oy = 0;
            for (int c = 0; c + K <= size; c += stride) begin
                for (int x = 0; x < K; x++)
                    for (int y = 0; y < K; y++)
                        w.addr[x*K + y] = AW'(base + (r + x)*size + c + y);
                w.x    = DW'(ox);
                w.y    = DW'(oy);
                w.last = (r + stride + K > size) && (c + stride + K > size);
                sb.push_back(w);
                oy++;
            end
            ox++;
        end
    endtask

    task automatic start_pulse(input int size, input int stride, input int base);
        i_i_size     = DW'(size);
        i_stride     = SW'(stride);
        i_start_addr = AW'(base);
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
    endtask

    task automatic run_go(input int size, input int stride, input int base,
                          input int mode, output int accepted);
        int a0;
        bit got;
        a0 = acc_cnt;
        i_ready = 1'b1;
        start_pulse(size, stride, base);
        @(negedge i_clk);
        check("first_valid", 72'(o_valid), 72'(1));
        check("run_busy", 72'(o_busy), 72'(1));
        got = 1'b0;
        for (int c = 1; c < 200 && !got; c++) begin
            @(posedge i_clk); #1;
            if (mode == 1) i_ready = ((c % 4) == 0) || ((c % 4) == 3);
            @(negedge i_clk);
            if (o_done) got = 1'b1;
        end
        check("done_seen", 72'(got), 72'(1));
        if (got) begin
            check("done_valid", 72'(o_valid), 72'(0));
            check("done_busy", 72'(o_busy), 72'(1));
            @(negedge i_clk);
            check("idle_busy", 72'(o_busy), 72'(0));
            check("done_pulse", 72'(o_done), 72'(0));
        end
        check("sb_empty", 72'(sb.size()), 72'(0));
        i_ready  = 1'b1;
        accepted = acc_cnt - a0;
    endtask

    task automatic do_err(input int size, input int stride);
        start_pulse(size, stride, 0);
        @(negedge i_clk);
        check("err_pulse", 72'(o_error), 72'(1));
        check("err_valid", 72'(o_valid), 72'(0));
        check("err_busy", 72'(o_busy), 72'(0));
        @(negedge i_clk);
        check("err_end", 72'(o_error), 72'(0));
        check("err_busy2", 72'(o_busy), 72'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 72'(o_valid), 72'(0));
        check({tag, "_busy"}, 72'(o_busy), 72'(0));
        check({tag, "_done"}, 72'(o_done), 72'(0));
        check({tag, "_error"}, 72'(o_error), 72'(0));
        check({tag, "_last"}, 72'(o_last), 72'(0));
        check({tag, "_addr"}, 72'(o_addr), 72'(0));
        check({tag, "_xy"}, 72'({o_o_x, o_o_y}), 72'(0));
    endtask

    initial begin : stim
        int acc, a0, d0;
        i_nrst       = 1'b0;
        i_reg_clear  = 1'b0;
        i_start      = 1'b0;
        i_ready      = 1'b1;
        i_i_size     = '0;
        i_stride     = '0;
        i_start_addr = '0;
        #12;
        check_zero("reset");
        @(negedge i_clk);
        i_nrst = 1'b1;
        @(negedge i_clk);

        // Size 5, stride 1, base 0: nine windows back to back
        load_model(5, 1, 0);
        sb[0].addr = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
        sb[8].x = 6'd2; sb[8].y = 6'd2; sb[8].last = 1'b1;
        run_go(5, 1, 0, 0, acc);
        check("s1_count", 72'(acc), 72'(9));

        // Size 5, stride 2, base 16: four windows
        load_model(5, 2, 16);
        sb[3].addr = {8'd28, 8'd29, 8'd30, 8'd33, 8'd34, 8'd35, 8'd38, 8'd39, 8'd40};
        sb[3].x = 6'd1; sb[3].y = 6'd1; sb[3].last = 1'b1;
        run_go(5, 2, 16, 0, acc);
        check("s2_count", 72'(acc), 72'(4));

        // Size 4, stride 1 with toggled ready
        load_model(4, 1, 0);
        run_go(4, 1, 0, 1, acc);
        check("bp_count", 72'(acc), 72'(4));

        // Rejected configurations
        do_err(2, 1);
        do_err(5, 0);

        // Clear during the third window
        load_model(5, 1, 0);
        a0 = acc_cnt;
        i_ready = 1'b1;
        start_pulse(5, 1, 0);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1 i_ready = 1'b0; i_reg_clear = 1'b1;
        @(posedge i_clk); #1 i_reg_clear = 1'b0;
        @(negedge i_clk);
        check_zero("clear");
        check("clear_acc", 72'(acc_cnt - a0), 72'(2));
        sb.delete();
        d0 = done_cnt;
        repeat (12) @(negedge i_clk);
        check("clear_no_done", 72'(done_cnt - d0), 72'(0));
        i_ready = 1'b1;
        load_model(5, 1, 0);
        sb[0].addr = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
        run_go(5, 1, 0, 0, acc);
        check("restart_count", 72'(acc), 72'(9));

        // Base 250 wraps modulo 256
        load_model(5, 1, 250);
        sb[0].addr = {8'd250, 8'd251, 8'd252, 8'd255, 8'd0, 8'd1, 8'd4, 8'd5, 8'd6};
        run_go(5, 1, 250, 0, acc);
        check("wrap_count", 72'(acc), 72'(9));

        repeat (3) @(negedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/window_address_sequencer.md
# window_address_sequencer

Autonomous sliding-window address generator for the flash router. A single start pulse makes it walk every KERNEL_SIZE×KERNEL_SIZE window of a square input feature map at a programmable stride. For each window it presents the full tap-address vector with valid/ready flow control, so the router no longer computes output coordinates itself. It sits between the layer controller (config and start) and the flash read-request stage (address consumer).

## Interface
- ADDR_WIDTH, 8: width of each tap address and of i_start_addr.
- DIM_WIDTH, 6: width of input size and of output coordinates.
- STRIDE_WIDTH, 2: width of i_stride.
- KERNEL_SIZE, 3: window edge length; DATA_LENGTH = KERNEL_SIZE*KERNEL_SIZE (localparam).
- i_clk  in  1  clock, rising edge.
- i_nrst  in  1  asynchronous, active-low reset.
- i_reg_clear  in  1  synchronous clear; highest priority after reset.
- i_start  in  1  single-cycle start pulse; ignored unless the FSM is in IDLE.
- i_i_size  in  DIM_WIDTH  input map edge length (square map).
- i_stride  in  STRIDE_WIDTH  window step, in both row and column.
- i_start_addr  in  ADDR_WIDTH  base address of the map.
- i_ready  in  1  consumer accepts the current window.
- o_valid  out  1  o_addr/o_o_x/o_o_y/o_last hold a valid window.
- o_addr  out  [0:DATA_LENGTH-1][ADDR_WIDTH-1:0]  tap addresses, row-major within the window.
- o_o_x, o_o_y  out  DIM_WIDTH each  output-map coordinates (row, column) of the current window.
- o_last  out  1  current window is the final window of the map.
- o_busy  out  1  FSM is not in IDLE.
- o_done  out  1  one-cycle pulse after the last window is accepted.
- o_error  out  1  one-cycle pulse when a start is rejected because the configuration is invalid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + i_start:
  - Latch i_i_size, i_stride and i_start_addr.
  - If i_stride==0 or i_i_size<KERNEL_SIZE: pulse o_error and stay in IDLE.
  - Otherwise go to RUN with the window at row=0, col=0 (input coordinates) and out_x=0, out_y=0.
- Tap address: tap k = x*KERNEL_SIZE+y, with x,y in 0..KERNEL_SIZE-1. o_addr[k] = start_addr + (row+x)*size + (col+y), truncated modulo 2^ADDR_WIDTH. Intermediate products are wide enough to avoid overflow before the final truncation.
- Advance happens on a handshake (o_valid && i_ready):
  - If col+stride+KERNEL_SIZE ≤ size: col += stride, out_y += 1.
  - Else, if row+stride+KERNEL_SIZE ≤ size: col=0, out_y=0, row += stride, out_x += 1.
  - Else, the last window was accepted: go to DONE.
- o_last is asserted when neither advance condition holds for the current window. No divider is used.
- DONE: o_done=1 for one cycle, then return to IDLE.
- i_start while busy is ignored. Configuration inputs are not sampled after the start cycle.
- i_reg_clear, in any state: next cycle the FSM is in IDLE and all outputs are 0. Any in-flight window is dropped without o_done.

## Timing
- Reset and i_reg_clear values: every output is 0, and the state is IDLE.
- All outputs are registered.
- First window: i_start accepted in cycle N → o_valid=1 in cycle N+1.
- Throughput: one window per cycle while i_ready=1. o_valid stays high between back-to-back windows.
- Backpressure: while o_valid=1 && i_ready=0, o_addr, o_o_x, o_o_y and o_last are held stable.
- Done timing: last handshake in cycle M → o_valid=0, o_done=1, o_busy=1 in cycle M+1 → IDLE and o_busy=0 in cycle M+2. A new i_start is accepted from cycle M+2.
- Error timing: rejected start in cycle N → o_error=1 in cycle N+1, and o_busy stays 0.
- Reset asserted mid-run: outputs go to 0 asynchronously.

## Structure
- Shared package addr_gen_pkg holds:
  - typedef enum of the state (IDLE, RUN, DONE).
  - Default-width localparams.
- Sub-module window_tap_addr (combinational): takes start_addr, size, row and col, and produces the DATA_LENGTH tap addresses through a KERNEL_SIZE×KERNEL_SIZE generate loop. The sequencer registers its output into o_addr.

## Test plan
- Size 5, stride 1, base 0, i_ready=1 → 9 windows on consecutive cycles. First o_addr = {0,1,2,5,6,7,10,11,12}. o_last on (2,2). o_done one cycle after.
- Size 5, stride 2, base 16 → 4 windows, (o_o_x,o_o_y) = (0,0),(0,1),(1,0),(1,1). Last o_addr = {28,29,30,33,34,35,38,39,40}.
- Size 4, stride 1 with i_ready toggled 1,0,0,1… → outputs held stable while i_ready=0. Exactly 4 windows accepted, none skipped or duplicated.
- i_i_size=2, or i_stride=0 → o_error pulse one cycle after start. o_valid and o_busy stay 0.
- i_reg_clear asserted during the third window → all outputs 0 next cycle, no o_done. A fresh start then restarts from window (0,0).
- ADDR_WIDTH=8, base 250, size 5 → first window taps wrap modulo 256: {250,251,252,255,0,1,4,5,6}.
